// File: rtl/matrix_frame_buf_if.sv
// rtl/matrix_frame_buf_if.sv - host write/swap port and matrix controller read port bundle
interface matrix_frame_buf_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       swap_req;
    logic       clear_req;
    logic       swap_pending;
    logic       swap_ack;
    logic       swap_forced;
    logic [2:0] disp_addr;
    logic [7:0] disp_data;

    modport master (
        output wr_en, wr_addr, wr_data, swap_req, clear_req, disp_addr,
        input  wr_ready, swap_pending, swap_ack, swap_forced, disp_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, swap_req, clear_req, disp_addr,
        output wr_ready, swap_pending, swap_ack, swap_forced, disp_data
    );
endinterface

// File: rtl/matrix_frame_buf.sv
// rtl/matrix_frame_buf.sv - double-buffered 8x8 frame store with frame-aligned swap
module matrix_frame_buf #(
    parameter int SWAP_TIMEOUT = 65535,
    parameter int TO_W         = 16
) (
    input  logic               clk,
    input  logic               reset,
    matrix_frame_buf_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_PENDING = 2'd2
    } state_t;

    state_t          state;
    logic [7:0]      bank [2][8];
    logic            front_sel;
    logic [2:0]      addr_q;
    logic [2:0]      clr_row;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      disp_data_q;
    logic            wr_ready_q;
    logic            swap_pending_q;
    logic            swap_ack_q;
    logic            swap_forced_q;

    logic fb;
    logic timeout;
    logic swap_now;
    logic front_sel_next;

    // A boundary and a timeout on the same cycle count as a normal swap.
    assign fb             = (addr_q == 3'd7) && (bus.disp_addr == 3'd0);
    assign timeout        = (to_cnt == TO_W'(SWAP_TIMEOUT - 1));
    assign swap_now       = (state == S_PENDING) && (fb || timeout);
    assign front_sel_next = front_sel ^ swap_now;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 8; r++)
                    bank[b][r] <= 8'd0;
            state          <= S_IDLE;
            front_sel      <= 1'b0;
            addr_q         <= 3'd0;
            clr_row        <= 3'd0;
            to_cnt         <= '0;
            disp_data_q    <= 8'd0;
            wr_ready_q     <= 1'b1;
            swap_pending_q <= 1'b0;
            swap_ack_q     <= 1'b0;
            swap_forced_q  <= 1'b0;
        end else begin
            addr_q      <= bus.disp_addr;
            front_sel   <= front_sel_next;
            // Read via the post-edge front bank so row 0 of a new frame is already new.
            disp_data_q <= bank[front_sel_next][bus.disp_addr];
            swap_ack_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.clear_req) begin
                        state      <= S_CLEAR;
                        clr_row    <= 3'd0;
                        wr_ready_q <= 1'b0;
                    end else begin
                        if (bus.wr_en)
                            bank[~front_sel][bus.wr_addr] <= bus.wr_data;
                        if (bus.swap_req) begin
                            state          <= S_PENDING;
                            to_cnt         <= '0;
                            swap_forced_q  <= 1'b0;
                            wr_ready_q     <= 1'b0;
                            swap_pending_q <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    bank[~front_sel][clr_row] <= 8'd0;
                    clr_row <= clr_row + 3'd1;
                    if (clr_row == 3'd7) begin
                        state      <= S_IDLE;
                        wr_ready_q <= 1'b1;
                    end
                end
                S_PENDING: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (swap_now) begin
                        state          <= S_IDLE;
                        swap_ack_q     <= 1'b1;
                        wr_ready_q     <= 1'b1;
                        swap_pending_q <= 1'b0;
                        if (!fb)
                            swap_forced_q <= 1'b1;
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    wr_ready_q     <= 1'b1;
                    swap_pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.disp_data    = disp_data_q;
    assign bus.wr_ready     = wr_ready_q;
    assign bus.swap_pending = swap_pending_q;
    assign bus.swap_ack     = swap_ack_q;
    assign bus.swap_forced  = swap_forced_q;
endmodule

// File: tb/tb_matrix_frame_buf.sv
// tb/tb_matrix_frame_buf.sv - randomized and directed self-checking bench for matrix_frame_buf
module tb_matrix_frame_buf;
    localparam int T = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    matrix_frame_buf_if bus ();

    matrix_frame_buf #(.SWAP_TIMEOUT(T), .TO_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_cnt = 0;
    int pend_cnt = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 clearing, 2 waiting for swap.
    logic [7:0] m_bank [2][8];
    int   m_front, m_mode, m_cleared, m_waited, m_prev_addr;
    logic [7:0] e_disp;
    logic e_ack, e_forced;

    always @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 8; r++)
                    m_bank[b][r] = 8'd0;
            m_front = 0; m_mode = 0; m_cleared = 0; m_waited = 0; m_prev_addr = 0;
            e_disp = 8'd0; e_ack = 1'b0; e_forced = 1'b0;
        end else begin
            bit boundary, do_swap;
            boundary = (m_prev_addr == 7) && (bus.disp_addr == 3'd0);
            do_swap = 1'b0;
            e_ack = 1'b0;
            if (m_mode == 0) begin
                if (bus.clear_req) begin
                    m_mode = 1; m_cleared = 0;
                end else begin
                    if (bus.wr_en) m_bank[1 - m_front][bus.wr_addr] = bus.wr_data;
                    if (bus.swap_req) begin
                        m_mode = 2; m_waited = 0; e_forced = 1'b0;
                    end
                end
            end else if (m_mode == 1) begin
                m_bank[1 - m_front][m_cleared] = 8'd0;
                m_cleared++;
                if (m_cleared == 8) m_mode = 0;
            end else begin
                m_waited++;
                if (boundary || m_waited == T) begin
                    do_swap = 1'b1;
                    e_ack = 1'b1;
                    if (!boundary) e_forced = 1'b1;
                    m_mode = 0;
                end
            end
            if (do_swap) m_front = 1 - m_front;
            e_disp = m_bank[m_front][bus.disp_addr];
            m_prev_addr = int'(bus.disp_addr);
        end
    end

    always @(negedge clk) begin
        check("disp_data",    bus.disp_data,           e_disp);
        check("wr_ready",     {7'd0, bus.wr_ready},     {7'd0, m_mode == 0});
        check("swap_pending", {7'd0, bus.swap_pending}, {7'd0, m_mode == 2});
        check("swap_ack",     {7'd0, bus.swap_ack},     {7'd0, e_ack});
        check("swap_forced",  {7'd0, bus.swap_forced},  {7'd0, e_forced});
    end

    task automatic step(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic sr, input logic cr, input logic [2:0] da);
        bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
        bus.swap_req = sr; bus.clear_req = cr; bus.disp_addr = da;
        @(posedge clk);
        @(negedge clk);
        if (bus.swap_ack) ack_cnt++;
        if (bus.swap_pending) pend_cnt++;
    endtask

    task automatic idle(input logic [2:0] da);
        step(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, da);
    endtask

    initial begin
        int lo_cnt;
        logic [2:0] da;
        bus.wr_en = 1'b0; bus.wr_addr = 3'd0; bus.wr_data = 8'd0;
        bus.swap_req = 1'b0; bus.clear_req = 1'b0; bus.disp_addr = 3'd7;

        reset = 1'b0;
        idle(3'd7); idle(3'd7);
        reset = 1'b1;
        check("rst_disp", bus.disp_data, 8'h00);
        check("rst_ready", {7'd0, bus.wr_ready}, 8'h01);
        check("rst_pending", {7'd0, bus.swap_pending}, 8'h00);

        for (int r = 0; r < 8; r++) step(1'b1, 3'(r), 8'(1 << r), 1'b0, 1'b0, 3'd7);
        ack_cnt = 0;
        step(1'b0, 3'd0, 8'd0, 1'b1, 1'b0, 3'd7);
        check("pre_swap_disp", bus.disp_data, 8'h00);
        for (int r = 0; r < 8; r++) begin
            idle(3'(r));
            check("sweep_row", bus.disp_data, 8'(1 << r));
        end
        check("sweep_acks", 8'(ack_cnt), 8'd1);

        step(1'b1, 3'd3, 8'hFF, 1'b0, 1'b0, 3'd3);
        idle(3'd3);
        check("back_write_hidden", bus.disp_data, 8'h08);

        ack_cnt = 0; pend_cnt = 0;
        step(1'b0, 3'd0, 8'd0, 1'b1, 1'b0, 3'd4);
        for (int i = 0; i < 40 && ack_cnt == 0; i++) idle(3'd4);
        check("forced_pending_cycles", 8'(pend_cnt), 8'd16);
        check("forced_ack", 8'(ack_cnt), 8'd1);
        check("forced_flag", {7'd0, bus.swap_forced}, 8'h01);
        step(1'b0, 3'd0, 8'd0, 1'b1, 1'b0, 3'd4);
        check("forced_cleared", {7'd0, bus.swap_forced}, 8'h00);
        idle(3'd7); idle(3'd0);

        step(1'b1, 3'd2, 8'hAA, 1'b0, 1'b1, 3'd0);
        lo_cnt = bus.wr_ready ? 0 : 1;
        for (int i = 0; i < 20 && !bus.wr_ready; i++) begin
            idle(3'd0);
            if (!bus.wr_ready) lo_cnt++;
        end
        check("clear_busy_cycles", 8'(lo_cnt), 8'd8);
        step(1'b0, 3'd0, 8'd0, 1'b1, 1'b0, 3'd7);
        for (int r = 0; r < 8; r++) begin
            idle(3'(r));
            check("cleared_row", bus.disp_data, 8'h00);
        end

        step(1'b0, 3'd0, 8'd0, 1'b1, 1'b0, 3'd4);
        idle(3'd4);
        reset = 1'b0;
        idle(3'd4);
        reset = 1'b1;
        check("midrst_disp", bus.disp_data, 8'h00);
        check("midrst_pending", {7'd0, bus.swap_pending}, 8'h00);
        ack_cnt = 0;
        for (int i = 0; i < 20; i++) idle(3'd4);
        check("midrst_no_ack", 8'(ack_cnt), 8'd0);

        da = 3'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) != 0) da = da + 3'd1;
            else da = 3'($urandom_range(0, 7));
            reset = ($urandom_range(0, 499) != 0);
            step($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 8'($urandom),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0, da);
        end
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/matrix_frame_buf.md
# matrix_frame_buf

Double-buffered 8x8 frame store that sits directly upstream of the MAX7219 matrix controller in the DE0-Nano/NIOS II display path. The host (NIOS II PIO/bridge logic) writes rows into a back buffer. The matrix controller reads the front buffer through its `disp_addr`/`disp_data` pair. A requested buffer swap is deferred to the next frame boundary so the matrix never shows a torn frame, and a timeout forces the swap if the controller stalls.

## Interface
- `SWAP_TIMEOUT`, default 65535: number of clk cycles a pending swap waits for a frame boundary before the swap is forced. Must be ≥ 1.
- `TO_W`, default 16: width of the timeout counter. Must satisfy 2^TO_W > SWAP_TIMEOUT.

- `clk`  in  1  system clock; also clocks the matrix controller's prescaler source.
- `reset`  in  1  one clock; reset is synchronous and active-low.
- `wr_en`  in  1  host row write strobe; accepted only when `wr_ready`=1.
- `wr_addr`  in  3  back-buffer row index 0..7.
- `wr_data`  in  8  row pattern.
- `wr_ready`  out  1  high in IDLE only.
- `swap_req`  in  1  single-cycle pulse: request a front/back exchange.
- `clear_req`  in  1  single-cycle pulse: zero the back buffer.
- `swap_pending`  out  1  high in PENDING.
- `swap_ack`  out  1  one-cycle pulse on the cycle after the swap takes effect.
- `swap_forced`  out  1  sticky; set when a swap was taken by timeout; cleared by the next `swap_req` acceptance.
- `disp_addr`  in  3  row address from the matrix controller.
- `disp_data`  out  8  registered front-buffer row for `disp_addr`.

## Operation
- Storage: two 8x8-bit banks `bank[0]` and `bank[1]`. Register `front_sel` selects the front bank; the back bank is `~front_sel`.
- Frame boundary (`fb`): `addr_q`==7 and `disp_addr`==0, where `addr_q` is `disp_addr` registered on clk. The controller emits 7 during init and then 0..7 per frame, so `fb` fires once per frame start.
- FSM states:
  - **IDLE**:
    - `clear_req` → CLEAR, with clear row counter = 0.
    - else `swap_req` → PENDING, with timeout counter = 0. `swap_forced` is cleared.
    - `wr_en` writes `bank[~front_sel][wr_addr]` <= `wr_data`, in IDLE regardless of other requests, except when `clear_req` is also asserted. In that case clear wins and the write is dropped.
  - **CLEAR**:
    - Writes 0 to one back-bank row per cycle, rows 0..7.
    - After row 7 → IDLE. Takes 8 cycles.
    - `wr_en`, `swap_req` and `clear_req` are ignored.
  - **PENDING**:
    - The timeout counter increments each cycle.
    - On `fb`: toggle `front_sel` → IDLE, `swap_ack`=1 next cycle.
    - Else, when the counter == SWAP_TIMEOUT-1: toggle, → IDLE, `swap_ack`=1, `swap_forced`=1.
    - `wr_en`, `swap_req` and `clear_req` are ignored.
- Read path: `disp_data` <= `bank[front_sel_next][disp_addr]`, where `front_sel_next` is the value `front_sel` takes at this edge. Row 0 of a new frame therefore already comes from the new front bank.
- Dropped requests are silent. The host polls `wr_ready`/`swap_pending`.

## Timing
- Reset (`reset`=0 at a rising edge):
  - both banks = 0, `front_sel`=0, `addr_q`=0;
  - state = IDLE, counters = 0;
  - `disp_data`=0, `swap_ack`=0, `swap_forced`=0, `swap_pending`=0, `wr_ready`=1 (IDLE).
- Reset asserted mid-CLEAR or mid-PENDING aborts the operation; no `swap_ack` is produced.
- Write latency: a write accepted at edge n is visible in the bank after edge n. It appears on `disp_data` only after a swap.
- Read latency: `disp_data` reflects the `disp_addr` sampled at the previous edge (1 clk). This is far below the controller's clk/8 shift period.
- Swap latency:
  - Normal case: at most one frame, taken on the first `fb` after entering PENDING.
  - Forced case: exactly SWAP_TIMEOUT cycles after entry.
- `swap_ack` goes high the cycle after `front_sel` toggles, for 1 cycle. `wr_ready` returns high on that same cycle.
- `fb` on the first PENDING cycle (request in the cycle before a boundary) is honoured.
- `fb` and timeout on the same cycle: treated as a normal swap, so `swap_forced` is not set.
- `fb` while in IDLE or CLEAR has no effect.

## Test plan
- Reset, then write rows 0..7 = 8'h01,02,04,…,80. Pulse `swap_req`, then drive `disp_addr` 7→0..7. Required response:
  - `swap_ack` pulses once;
  - `disp_data` reads 01..80 with 1-cycle lag, starting at row 0;
  - before the swap `disp_data` stays 0.
- Write 8'hFF to row 3 of the back buffer while the front buffer is displayed → `disp_data` for row 3 is unchanged (old value) until the next swap.
- `swap_req` with `disp_addr` held at 4 and SWAP_TIMEOUT=16 → `swap_pending` is high for 16 cycles, then `swap_ack`=1 and `swap_forced`=1. The next `swap_req` clears `swap_forced`.
- `clear_req` and `wr_en` (row 2, 8'hAA) in the same cycle → `wr_ready`=0 for 8 cycles. After a swap, all rows read 0, including row 2.
- `swap_req` arriving one cycle before the 7→0 transition → swap is taken on that boundary, and row 0 is read from the new bank.
- Assert `reset` mid-PENDING → `swap_ack` never pulses, `front_sel`=0, and `disp_data`=0 on the next cycle.
